// File: rtl/krz_wb_master.sv
// krz_wb_master: Wishbone classic initiator for the KRZ register-file slaves.
// Turns one valid/ready request into one Wishbone bus cycle and hands the
// result back on a valid/ready response channel. One transaction at a time.
// Optional bus timeout is enabled by defining KRZ_WBM_TIMEOUT_EN; without it
// the master waits for ack_i indefinitely and rsp_err is tied low.
module krz_wb_master #(
  parameter int AW      = 6,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] adr_o,
  output logic [31:0]   dat_o,
  input  logic [31:0]   dat_i,
  output logic          we_o,
  output logic          stb_o,
  output logic          cyc_o,
  input  logic          ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

  // Reject a timeout value the 16-bit counter cannot represent
  generate
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("krz_wb_master: TIMEOUT must be in 1..65535");
    end
  endgenerate

`ifdef KRZ_WBM_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] to_cnt;
`else
  // Without the timeout no transaction can end in error
  assign rsp_err = 1'b0;
`endif

  // Only the request handshake is combinational; everything else is registered
  assign req_ready = (state == IDLE);

  // Transaction sequencer: request capture, bus cycle, response hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      stb_o     <= 1'b0;
      cyc_o     <= 1'b0;
      we_o      <= 1'b0;
      adr_o     <= '0;
      dat_o     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef KRZ_WBM_TIMEOUT_EN
      rsp_err   <= 1'b0;
      to_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_o   <= req_we;
            adr_o  <= req_addr;
            dat_o  <= req_wdata;
            stb_o  <= 1'b1;
            cyc_o  <= 1'b1;
`ifdef KRZ_WBM_TIMEOUT_EN
            to_cnt <= '0;
`endif
            state  <= BUS;
          end
        end

        BUS: begin
          if (ack_i) begin
            stb_o     <= 1'b0;
            cyc_o     <= 1'b0;
            rsp_rdata <= we_o ? 32'd0 : dat_i;
            rsp_valid <= 1'b1;
`ifdef KRZ_WBM_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= RESP;
          end
`ifdef KRZ_WBM_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            stb_o     <= 1'b0;
            cyc_o     <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
